// File: rtl/scarv_cop_ctx_pkg.sv
// rtl/scarv_cop_ctx_pkg.sv - shared encodings for the COP context save/restore engine
package scarv_cop_ctx_pkg;

    localparam int unsigned CTX_NUM_CPR = 16;
    localparam int unsigned CTX_XLEN    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } ctx_state_t;

    localparam logic CTX_SAVE    = 1'b0;
    localparam logic CTX_RESTORE = 1'b1;

    // Word address of CPR idx inside a context block starting at base.
    function automatic logic [31:0] ctx_slot_offset(input logic [3:0] idx);
        return {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/scarv_cop_ffs16.sv
// rtl/scarv_cop_ffs16.sv - lowest-set-bit encoder for a 16-bit mask
module scarv_cop_ffs16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_any
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        o_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
        o_any = |i_vec;
    end

endmodule

// File: rtl/scarv_cop_ctx.sv
// rtl/scarv_cop_ctx.sv - CPR context save/restore engine between register file and memory
module scarv_cop_ctx
    import scarv_cop_ctx_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        ctx_valid,
    input  logic        ctx_op,
    input  logic [31:0] ctx_base,
    input  logic [15:0] ctx_mask,
    output logic        ctx_ready,
    output logic        ctx_error,
    output logic        crs_ren,
    output logic [3:0]  crs_addr,
    input  logic [31:0] crs_rdata,
    output logic [3:0]  crd_wen,
    output logic [3:0]  crd_addr,
    output logic [31:0] crd_wdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_ben,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    ctx_state_t  r_state;
    ctx_state_t  w_state_next;
    logic        r_op;
    logic [31:0] r_base;
    logic [15:0] r_remaining;
    logic        r_error;

    logic [15:0] w_ffs_in;
    logic [3:0]  w_idx;
    logic        w_any;
    logic [31:0] w_addr;
    logic [15:0] w_rem_clr;
    logic        w_misaligned;

    // In IDLE the encoder looks at the incoming mask so an empty mask is
    // detected on acceptance; afterwards it tracks the latched remaining set.
    assign w_ffs_in     = (r_state == ST_IDLE) ? ctx_mask : r_remaining;
    assign w_misaligned = (ctx_base[1:0] != 2'b00);
    assign w_addr       = r_base + ctx_slot_offset(w_idx);
    assign w_rem_clr    = r_remaining & ~(16'd1 << w_idx);

    scarv_cop_ffs16 u_ffs (
        .i_vec (w_ffs_in),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operation context: op, base, bits still to transfer, sticky error.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_op        <= CTX_SAVE;
            r_base      <= 32'd0;
            r_remaining <= 16'd0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctx_valid) begin
                        r_op        <= ctx_op;
                        r_base      <= ctx_base;
                        r_remaining <= w_misaligned ? 16'd0 : ctx_mask;
                        r_error     <= w_misaligned;
                    end
                end
                ST_RSP: begin
                    if (mem_rvalid) begin
                        if (mem_error) begin
                            r_error     <= 1'b1;
                            r_remaining <= 16'd0;
                        end else begin
                            r_remaining <= w_rem_clr;
                        end
                    end
                end
                ST_DONE: begin
                    r_error     <= 1'b0;
                    r_remaining <= 16'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and all outputs; every output idles at zero.
    always_comb begin
        w_state_next = r_state;
        ctx_ready    = 1'b0;
        ctx_error    = 1'b0;
        crs_ren      = 1'b0;
        crs_addr     = 4'd0;
        crd_wen      = 4'd0;
        crd_addr     = 4'd0;
        crd_wdata    = 32'd0;
        mem_req      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_ben      = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (ctx_valid) begin
                    if (w_misaligned || !w_any) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_wen  = (r_op == CTX_SAVE);
                mem_addr = w_addr;
                mem_ben  = 4'hF;
                if (r_op == CTX_SAVE) begin
                    crs_ren   = 1'b1;
                    crs_addr  = w_idx;
                    mem_wdata = crs_rdata;
                end
                if (mem_gnt) begin
                    w_state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rvalid) begin
                    if (mem_error) begin
                        w_state_next = ST_DONE;
                    end else begin
                        if (r_op == CTX_RESTORE) begin
                            crd_wen   = 4'hF;
                            crd_addr  = w_idx;
                            crd_wdata = mem_rdata;
                        end
                        w_state_next = (w_rem_clr == 16'd0) ? ST_DONE : ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                ctx_ready    = 1'b1;
                ctx_error    = r_error;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scarv_cop_ctx.sv
// tb/tb_scarv_cop_ctx.sv - self-checking bench for scarv_cop_ctx
module tb_scarv_cop_ctx;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        ctx_valid;
    logic        ctx_op;
    logic [31:0] ctx_base;
    logic [15:0] ctx_mask;
    logic        ctx_ready;
    logic        ctx_error;
    logic        crs_ren;
    logic [3:0]  crs_addr;
    logic [31:0] crs_rdata;
    logic [3:0]  crd_wen;
    logic [3:0]  crd_addr;
    logic [31:0] crd_wdata;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_ben;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_error;

    always #5 g_clk = ~g_clk;

    scarv_cop_ctx dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .ctx_valid  (ctx_valid),
        .ctx_op     (ctx_op),
        .ctx_base   (ctx_base),
        .ctx_mask   (ctx_mask),
        .ctx_ready  (ctx_ready),
        .ctx_error  (ctx_error),
        .crs_ren    (crs_ren),
        .crs_addr   (crs_addr),
        .crs_rdata  (crs_rdata),
        .crd_wen    (crd_wen),
        .crd_addr   (crd_addr),
        .crd_wdata  (crd_wdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ben    (mem_ben),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error)
    );

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ren;
        logic [3:0]  raddr;
    } acc_t;

    typedef struct {
        logic        op;
        logic [31:0] base;
        logic [15:0] mask;
        int          gw;
        int          rd;
        int          err_at;
        int          exp_lat;
        logic        exp_err;
        int          exp_nacc;
    } vec_t;

    logic [31:0] cpr [16];
    logic [31:0] mem [logic [31:0]];
    assign crs_rdata = cpr[crs_addr];

    acc_t log_q[$];
    acc_t exp_q[$];
    logic [31:0] exp_cpr [16];

    int n_cmp = 0;
    int n_bad = 0;

    int gw_cfg, rd_cfg, err_at_cfg;
    int gnt_wait, rsp_wait, acc_n, cyc_k;
    bit rsp_pending, pend_err, prev_wait;
    logic [31:0] pend_rdata;
    logic [69:0] prev_fields;
    int stab_err, ben_err, act_cnt, wr_cnt, ready_cnt, ready_lat;
    logic ready_err;
    int exp_lat_m, exp_wr_m;
    logic exp_err_m;

    vec_t vecs [7];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [116:0] all_outs();
        return {ctx_ready, ctx_error, crs_ren, crs_addr, crd_wen, crd_addr, crd_wdata,
                mem_req, mem_wen, mem_addr, mem_wdata, mem_ben};
    endfunction

    // One clock of the memory/register-file environment; entered and left at negedge.
    task automatic cycle();
        bit gave_rvalid = 0;
        bit granted = 0;
        bit do_wr = 0;
        bit saw_ready = 0;
        logic [3:0]  wa = 0;
        logic [31:0] wd = 0;
        acc_t a;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_error = 0;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                mem_rvalid = 1; mem_rdata = pend_rdata; mem_error = pend_err; gave_rvalid = 1;
            end else rsp_wait--;
        end else if (mem_req) begin
            if (gnt_wait == 0) mem_gnt = 1; else gnt_wait--;
        end
        #1;
        if (mem_req) begin
            if (prev_wait && {mem_wen, mem_addr, mem_wdata, crs_ren, crs_addr} !== prev_fields) stab_err++;
            if (mem_ben !== 4'hF) ben_err++;
        end
        prev_wait = mem_req && !mem_gnt;
        prev_fields = {mem_wen, mem_addr, mem_wdata, crs_ren, crs_addr};
        if (mem_req || crs_ren || (crd_wen != 0)) act_cnt++;
        if (mem_req && mem_gnt) begin
            a = '{wen: mem_wen, addr: mem_addr, wdata: mem_wdata, ren: crs_ren, raddr: crs_addr};
            log_q.push_back(a);
            pend_err = (acc_n == err_at_cfg);
            pend_rdata = mem_wen ? 32'd0 : mem_rd(mem_addr);
            if (mem_wen) mem[mem_addr] = mem_wdata;
            acc_n++;
            granted = 1;
        end
        if (crd_wen != 0) begin
            wr_cnt++;
            if (crd_wen !== 4'hF) ben_err++;
            do_wr = 1; wa = crd_addr; wd = crd_wdata;
        end
        if (ctx_ready) begin
            ready_cnt++; ready_lat = cyc_k; ready_err = ctx_error; saw_ready = 1;
        end
        @(posedge g_clk);
        if (do_wr) cpr[wa] = wd;
        if (granted) begin rsp_pending = 1; rsp_wait = rd_cfg; gnt_wait = gw_cfg; end
        if (gave_rvalid) rsp_pending = 0;
        cyc_k++;
        @(negedge g_clk);
        if (saw_ready) ctx_valid = 0;
    endtask

    // Reference: transfer walk over the selected CPRs in ascending order.
    task automatic build_model(input logic op, input logic [31:0] base, input logic [15:0] mask,
                               input int gw, input int rd, input int err_at);
        int n = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_cpr[i] = cpr[i];
        exp_err_m = 0; exp_lat_m = 1; exp_wr_m = 0;
        if (base[1:0] != 2'b00) begin
            exp_err_m = 1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (mask[i]) begin
                    acc_t e;
                    e.wen   = !op;
                    e.addr  = base + 32'(4 * i);
                    e.wdata = op ? 32'd0 : cpr[i];
                    e.ren   = !op;
                    e.raddr = op ? 4'd0 : 4'(i);
                    exp_q.push_back(e);
                    exp_lat_m += gw + 1 + rd + 1;
                    if (n == err_at) begin
                        exp_err_m = 1;
                        break;
                    end
                    if (op) begin
                        exp_cpr[i] = mem_rd(e.addr);
                        exp_wr_m++;
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic start_op(input logic op, input logic [31:0] base, input logic [15:0] mask,
                            input int gw, input int rd, input int err_at);
        log_q.delete();
        gw_cfg = gw; rd_cfg = rd; err_at_cfg = err_at;
        gnt_wait = gw; acc_n = 0; prev_wait = 0; cyc_k = 0;
        stab_err = 0; ben_err = 0; act_cnt = 0; wr_cnt = 0; ready_cnt = 0; ready_lat = -1; ready_err = 0;
        ctx_valid = 1; ctx_op = op; ctx_base = base; ctx_mask = mask;
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] base, input logic [15:0] mask,
                          input int gw, input int rd, input int err_at);
        build_model(op, base, mask, gw, rd, err_at);
        start_op(op, base, mask, gw, rd, err_at);
        while (ready_cnt == 0 && cyc_k < 400) cycle();
        ctx_valid = 0;
        cycle();
        cycle();
        chk({tag, " ready_count"}, ready_cnt, 1);
        chk({tag, " latency"}, ready_lat, exp_lat_m);
        chk({tag, " error"}, ready_err, exp_err_m);
        chk({tag, " n_access"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            acc_t g = (i < log_q.size()) ? log_q[i] : '0;
            chk($sformatf("%s access%0d", tag, i), g, exp_q[i]);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("%s cpr%0d", tag, i), cpr[i], exp_cpr[i]);
        chk({tag, " cpr_writes"}, wr_cnt, exp_wr_m);
        chk({tag, " req_stable"}, stab_err, 0);
        chk({tag, " byte_enables"}, ben_err, 0);
        if (exp_q.size() == 0) chk({tag, " no_activity"}, act_cnt, 0);
    endtask

    initial begin
        g_resetn = 0; ctx_valid = 0; ctx_op = 0; ctx_base = 0; ctx_mask = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_error = 0;
        rsp_pending = 0; rsp_wait = 0; pend_err = 0; pend_rdata = 0;
        for (int i = 0; i < 16; i++) cpr[i] = 32'hC0DE_0000 | i;
        cpr[0] = 32'hA5A5_0001;
        cpr[2] = 32'h0000_BEEF;
        mem[32'h2000] = 32'h1111_1111;
        mem[32'h203C] = 32'hFFFF_0000;

        vecs[0] = '{1'b0, 32'h1000, 16'h0005, 0, 0, -1, 5, 1'b0, 2};
        vecs[1] = '{1'b1, 32'h2000, 16'h8001, 0, 0, -1, 5, 1'b0, 2};
        vecs[2] = '{1'b0, 32'h3000, 16'hFFFF, 3, 0, -1, 81, 1'b0, 16};
        vecs[3] = '{1'b1, 32'h5000, 16'h0007, 0, 0, 1, 5, 1'b1, 2};
        vecs[4] = '{1'b0, 32'h1002, 16'hFFFF, 0, 0, -1, 1, 1'b1, 0};
        vecs[5] = '{1'b1, 32'h6000, 16'h0000, 0, 0, -1, 1, 1'b0, 0};
        vecs[6] = '{1'b1, 32'h7000, 16'h0240, 2, 1, -1, 11, 1'b0, 2};

        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        g_resetn = 1;
        @(negedge g_clk);

        for (int v = 0; v < 7; v++) begin
            string tag = $sformatf("vec%0d", v);
            run_op(tag, vecs[v].op, vecs[v].base, vecs[v].mask, vecs[v].gw, vecs[v].rd, vecs[v].err_at);
            chk({tag, " tbl_latency"}, ready_lat, vecs[v].exp_lat);
            chk({tag, " tbl_error"}, ready_err, vecs[v].exp_err);
            chk({tag, " tbl_n_access"}, log_q.size(), vecs[v].exp_nacc);
            if (v == 0) begin
                chk("vec0 mem1000", mem_rd(32'h1000), 32'hA5A5_0001);
                chk("vec0 mem1008", mem_rd(32'h1008), 32'h0000_BEEF);
            end
            if (v == 1) begin
                chk("vec1 cpr0", cpr[0], 32'h1111_1111);
                chk("vec1 cpr15", cpr[15], 32'hFFFF_0000);
            end
        end

        // Reset during RSP of a save, then a stray response while idle.
        start_op(1'b0, 32'h4000, 16'h000F, 0, 0, -1);
        while (!rsp_pending && cyc_k < 20) cycle();
        chk("rst granted", rsp_pending, 1);
        g_resetn = 0; ctx_valid = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_error = 0;
        @(posedge g_clk);
        @(negedge g_clk);
        #1;
        chk("rst outputs_low", all_outs(), 0);
        g_resetn = 1;
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; mem_error = 1;
        #1;
        chk("rst stray_rvalid", all_outs(), 0);
        @(posedge g_clk);
        @(negedge g_clk);
        mem_rvalid = 0; mem_error = 0; mem_rdata = 0;
        #1;
        chk("rst idle_after", all_outs(), 0);
        rsp_pending = 0;
        @(negedge g_clk);
        run_op("post_rst", 1'b0, 32'h4000, 16'h000F, 0, 0, -1);

        // Randomized operations against the reference walk.
        for (int r = 0; r < 30; r++) begin
            logic        op   = 1'($urandom_range(0, 1));
            logic [31:0] base = $urandom & 32'hFFFF_FFFC;
            logic [15:0] mask = 16'($urandom);
            int          gw   = $urandom_range(0, 2);
            int          rd   = $urandom_range(0, 2);
            int          ea   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            if ($urandom_range(0, 7) == 0) base[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) mask = 16'd0;
            run_op($sformatf("rnd%0d", r), op, base, mask, gw, rd, ea);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
